wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter: DATA_W, default 16, width of write data.
REQ-002 Parameter: ADDR_W, default 5, register address width.
REQ-003 Parameter: CNT_W, default 8, width of the conflict counter.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port stall, input, 1; when high, no request is granted.
REQ-007 The block SHALL have ports r0_valid, r0_addr and r0_data (input, widths 1/ADDR_W/DATA_W): the ALU writeback requester.
REQ-008 The block SHALL have port r0_ready, output, 1: the ALU writeback requester's ready.
REQ-009 The block SHALL have ports r1_valid, r1_addr and r1_data (input, widths 1/ADDR_W/DATA_W): the load/debug requester.
REQ-010 The block SHALL have port r1_ready, output, 1: the load/debug requester's ready.
REQ-011 The block SHALL have ports we3 (output, 1), a3 (output, ADDR_W) and wd3 (output, DATA_W), all registered, driving the register-file write port.
REQ-012 The block SHALL have port conflicts, output, CNT_W: a saturating count of cycles in which both requesters were valid.

Function
REQ-013 A request SHALL transfer on a cycle where rN_valid and rN_ready are both high.
- The requester SHALL hold valid, addr and data stable until that transfer.
REQ-014 rN_ready SHALL be combinational from valid, stall and arbitration state.
- At most one rN_ready SHALL be high per cycle.
- rN_ready SHALL be high only when rN_valid is high.
REQ-015 With stall high, both readys SHALL be 0 and no transfer SHALL occur.
REQ-016 Arbitration states SHALL be PRI0 (r0 wins ties) and PRI1 (r1 wins ties).
- A single valid requester SHALL always be granted, regardless of state.
REQ-017 After a granted transfer from rN, the next arbitration state SHALL be PRI(1-N).
- With no transfer, the arbitration state SHALL hold.
REQ-018 A transfer SHALL drive we3=1, a3=addr and wd3=data in the next cycle: one-cycle latency.
REQ-019 A transfer with addr==0 (x0) SHALL be accepted, with ready high, but SHALL produce we3=0 next cycle.
- a3 and wd3 SHALL still update on an x0 transfer.
REQ-020 In a cycle with no transfer, the next cycle SHALL have we3=0.
- a3 and wd3 SHALL hold their values.
REQ-021 conflicts SHALL increment by 1 in each cycle where r0_valid, r1_valid and !stall are all high.
- It SHALL saturate at all-ones and never wrap.
REQ-022 Back-to-back transfers SHALL be supported every cycle: throughput 1 write per cycle.

Reset
REQ-023 While reset is low: we3=0, a3=0, wd3=0, conflicts=0, arbitration state=PRI0, both readys=0.
- These SHALL apply asynchronously on reset assertion.
REQ-024 Reset asserted mid-transfer SHALL discard that transfer; no write SHALL appear after reset release.
REQ-025 The first transfer SHALL be possible in the first rising edge after reset deasserts.

Configuration
REQ-026 Macro WB_ARB_RR_EN SHALL select the arbitration policy.
- Defined: round-robin per REQ-016/017.
- Undefined: fixed priority; the state SHALL stay at PRI0 permanently, so r0 always wins ties.
- REQ-021 and REQ-019 SHALL be unchanged in both builds.

Structure
REQ-027 A shared package SHALL hold:
- the arbitration state enum (PRI0, PRI1);
- the X0_ADDR constant (0);
- the default DATA_W, ADDR_W and CNT_W values.
REQ-028 One sub-module, sat_counter (parameter CNT_W, inputs inc/clk/reset, output count), SHALL implement REQ-021.
- All other logic SHALL be flat in wb_port_arbiter.

Verification
REQ-029 The bench SHALL cover these scenarios:
- Only r0_valid with addr=3, data=0x1234 -> r0_ready=1 same cycle; next cycle we3=1, a3=3, wd3=0x1234.
- Both valid for 4 cycles with WB_ARB_RR_EN defined -> grants r0,r1,r0,r1; conflicts=4.
- Same stimulus without WB_ARB_RR_EN -> r0 granted all 4 cycles; r1_ready stays 0.
- r1_valid with addr=0, data=0xFFFF -> r1_ready=1; next cycle we3=0.
- stall=1 with both valid -> both readys 0, we3=0 next cycle, conflicts unchanged.
- Reset pulled low during an accepted transfer -> we3=0, conflicts=0, state PRI0 immediately; no write after release.
- Also: 300 conflict cycles with CNT_W=8 -> conflicts=255 and holds.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared types and defaults for the register-file write-port arbiter.
package wb_port_arbiter_pkg;
    typedef enum logic {PRI0, PRI1} arb_state_t;
    localparam int X0_ADDR = 0;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/wb_port_arbiter_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: two-requester arbiter for one register-file write port.
// Define WB_ARB_RR_EN for round-robin tie-breaking; otherwise r0 always wins ties.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              r0_valid,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_data,
    output logic              r0_ready,
    input  logic              r1_valid,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_data,
    output logic              r1_ready,
    output logic              we3,
    output logic [ADDR_W-1:0] a3,
    output logic [DATA_W-1:0] wd3,
    output logic [CNT_W-1:0]  conflicts
);
    arb_state_t        state, state_nx;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= PRI0;
        else state <= state_nx;

    // Readys are gated by reset so nothing is offered while it is held low.
    always_comb begin
        r0_ready = reset && !stall && r0_valid && (!r1_valid || state == PRI0);
        r1_ready = reset && !stall && r1_valid && (!r0_valid || state == PRI1);
        xfer     = r0_ready || r1_ready;
        sel_addr = r0_ready ? r0_addr : r1_addr;
        sel_data = r0_ready ? r0_data : r1_data;
`ifdef WB_ARB_RR_EN
        state_nx = r0_ready ? PRI1 : r1_ready ? PRI0 : state;
`else
        state_nx = PRI0;
`endif
    end

    // Writes to x0 are accepted but suppressed at the write enable only.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            we3 <= 1'b0;
            a3  <= '0;
            wd3 <= '0;
        end else begin
            we3 <= xfer && sel_addr != ADDR_W'(X0_ADDR);
            if (xfer) begin
                a3  <= sel_addr;
                wd3 <= sel_data;
            end
        end

    sat_counter #(.CNT_W(CNT_W)) u_conflicts (
        .clk  (clk),
        .reset(reset),
        .inc  (r0_valid && r1_valid && !stall),
        .count(conflicts)
    );
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: scoreboard bench for wb_port_arbiter; follows WB_ARB_RR_EN if defined.
module tb_wb_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        r0_valid = 1'b0, r1_valid = 1'b0;
    logic [4:0]  r0_addr = '0, r1_addr = '0;
    logic [15:0] r0_data = '0, r1_data = '0;
    logic        r0_ready, r1_ready, we3;
    logic [4:0]  a3;
    logic [15:0] wd3;
    logic [7:0]  conflicts;

    typedef struct packed {logic we; logic [4:0] a; logic [15:0] d;} wr_t;
    wr_t exp_q[$];
    wr_t got, want;
    int n_chk = 0, n_pass = 0;
    bit m_pri1 = 1'b0;
    logic [4:0]  m_a3 = '0;
    logic [15:0] m_wd3 = '0;
    logic [7:0]  m_conf = '0;

    wb_port_arbiter dut (
        .clk(clk), .reset(reset), .stall(stall),
        .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_ready(r0_ready),
        .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_ready(r1_ready),
        .we3(we3), .a3(a3), .wd3(wd3), .conflicts(conflicts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pri1 = 1'b0;
        m_a3 = '0;
        m_wd3 = '0;
        m_conf = '0;
    endtask

    task automatic step(input logic v0, input logic [4:0] a0, input logic [15:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [15:0] d1,
                        input logic st);
        logic e0, e1;
        @(negedge clk);
        r0_valid = v0; r0_addr = a0; r0_data = d0;
        r1_valid = v1; r1_addr = a1; r1_data = d1;
        stall = st;
        e0 = v0 && !st && (!v1 || !m_pri1);
        e1 = v1 && !st && (!v0 || m_pri1);
        #1;
        chk("r0_ready", r0_ready, e0);
        chk("r1_ready", r1_ready, e1);
        if (e0) begin
            m_a3 = a0; m_wd3 = d0;
`ifdef WB_ARB_RR_EN
            m_pri1 = 1'b1;
`endif
            exp_q.push_back({a0 != 5'd0, a0, d0});
        end else if (e1) begin
            m_a3 = a1; m_wd3 = d1;
`ifdef WB_ARB_RR_EN
            m_pri1 = 1'b0;
`endif
            exp_q.push_back({a1 != 5'd0, a1, d1});
        end else exp_q.push_back({1'b0, m_a3, m_wd3});
        if (v0 && v1 && !st && m_conf != 8'hFF) m_conf++;
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        got = {we3, a3, wd3};
        chk("we3", got.we, want.we);
        chk("a3", got.a, want.a);
        chk("wd3", got.d, want.d);
        chk("conflicts", conflicts, m_conf);
    endtask

    initial begin
        r0_valid = 1'b1; r1_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we3", we3, 0);
        chk("rst_a3", a3, 0);
        chk("rst_wd3", wd3, 0);
        chk("rst_conf", conflicts, 0);
        chk("rst_r0_ready", r0_ready, 0);
        chk("rst_r1_ready", r1_ready, 0);
        @(negedge clk);
        r0_valid = 1'b0; r1_valid = 1'b0;
        reset = 1'b1;
        model_reset();

        step(1, 5'd3, 16'h1234, 0, 5'd0, 16'h0, 0);
        chk("first_we3", we3, 1);
        step(0, 5'd0, 16'h0, 1, 5'd0, 16'hFFFF, 0);
        chk("x0_we3", we3, 0);
        for (int i = 1; i <= 4; i++)
            step(1, 5'(i), 16'(16'h100 + i), 1, 5'(i + 8), 16'(16'h200 + i), 0);
        chk("conf4", conflicts, 4);
        step(1, 5'd5, 16'h5555, 1, 5'd6, 16'h6666, 1);
        chk("stall_we3", we3, 0);
        chk("stall_conf", conflicts, 4);
        for (int i = 0; i < 40; i++)
            step($urandom_range(0, 1), 5'($urandom), 16'($urandom),
                 $urandom_range(0, 1), 5'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);

        step(1, 5'd7, 16'hAAAA, 1, 5'd8, 16'hBBBB, 0);
        @(negedge clk);
        r0_valid = 1'b1; r0_addr = 5'd9; r0_data = 16'hCCCC;
        r1_valid = 1'b0; stall = 1'b0;
        #1;
        chk("pre_rst_ready", r0_ready, 1);
        #1 reset = 1'b0;
        #1;
        chk("async_we3", we3, 0);
        chk("async_a3", a3, 0);
        chk("async_wd3", wd3, 0);
        chk("async_conf", conflicts, 0);
        chk("async_r0_ready", r0_ready, 0);
        @(posedge clk);
        @(negedge clk);
        r0_valid = 1'b0;
        reset = 1'b1;
        model_reset();
        step(0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 0);
        chk("post_rst_we3", we3, 0);
        step(1, 5'd10, 16'h0A0A, 1, 5'd11, 16'h0B0B, 0);

        for (int i = 0; i < 300; i++)
            step(1, 5'(i % 31 + 1), 16'(i), 1, 5'(i % 29 + 1), 16'(~i), 0);
        chk("sat_conf", conflicts, 255);
        step(1, 5'd1, 16'h1, 1, 5'd2, 16'h2, 0);
        chk("sat_hold", conflicts, 255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
